// File: rtl/mm_counter_bank_pkg.sv
// Shared definitions for the multi-channel counter bank.
// Holds the per-channel register indices, the CTRL bit positions and the
// packed CTRL record used by the channel and the top-level read mux.
package mm_counter_bank_pkg;

  // Register index within one channel (low two address bits).
  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_STEP   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STROBE = 2'd3;

  // Bit positions inside CTRL.
  localparam int CTRL_EN  = 0;
  localparam int CTRL_DIR = 1;
  localparam int CTRL_SAT = 2;
  localparam int CTRL_OVF = 3;

  // Field order makes en land on bit 0, matching the bit positions above.
  typedef struct packed {
    logic ovf;
    logic sat;
    logic dir;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/mm_counter_chan.sv
// One counter channel: COUNT, STEP and CTRL registers plus step arithmetic.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_wr_count/step/ctrl  register write enables (already decoded)
//   i_strobe          one step event from a STROBE write
//   i_tick            external count event (gated by EN)
//   i_wdata           write data
//   o_count, o_step   current register values
//   o_ctrl            current CTRL record
module mm_counter_chan
  import mm_counter_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_count,
  input  logic             i_wr_step,
  input  logic             i_wr_ctrl,
  input  logic             i_strobe,
  input  logic             i_tick,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_step,
  output ctrl_t            o_ctrl
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_step;
  ctrl_t            r_ctrl;

  logic [1:0]       w_n;
  logic [WIDTH+1:0] w_delta;
  logic [WIDTH+1:0] w_up;
  logic [WIDTH-1:0] w_dn;
  logic             w_ovf;
  logic [WIDTH-1:0] w_next;

  // Up to two events per cycle: a strobe write and an enabled tick.
  assign w_n = {1'b0, i_strobe} + {1'b0, i_tick & r_ctrl.en};

  always_comb begin
    w_delta = '0;
    case (w_n)
      2'd1:    w_delta = {2'b00, r_step};
      2'd2:    w_delta = {1'b0, r_step, 1'b0};
      default: w_delta = '0;
    endcase
  end

  assign w_up = {2'b00, r_count} + w_delta;
  // Down result is only needed modulo 2^WIDTH; the borrow is detected by
  // comparing magnitudes instead.
  assign w_dn = r_count - w_delta[WIDTH-1:0];

  assign w_ovf = r_ctrl.dir ? (w_delta > {2'b00, r_count})
                            : (w_up[WIDTH+1:WIDTH] != 2'b00);

  always_comb begin
    w_next = '0;
    if (r_ctrl.sat && w_ovf)
      w_next = r_ctrl.dir ? '0 : '1;
    else
      w_next = r_ctrl.dir ? w_dn : w_up[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_step  <= WIDTH'(1);
      r_ctrl  <= '0;
    end else begin
      // A COUNT load discards any strobe/tick in the same cycle.
      if (i_wr_count)
        r_count <= i_wdata;
      else if (w_n != 2'd0)
        r_count <= w_next;

      if (i_wr_step)
        r_step <= i_wdata;

      if (i_wr_ctrl) begin
        r_ctrl.en  <= i_wdata[CTRL_EN];
        r_ctrl.dir <= i_wdata[CTRL_DIR];
        r_ctrl.sat <= i_wdata[CTRL_SAT];
      end

      // Setting the sticky flag wins over a write-1-to-clear.
      if (!i_wr_count && (w_n != 2'd0) && w_ovf)
        r_ctrl.ovf <= 1'b1;
      else if (i_wr_ctrl && i_wdata[CTRL_OVF])
        r_ctrl.ovf <= 1'b0;
    end
  end

  assign o_count = r_count;
  assign o_step  = r_step;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/mm_counter_bank.sv
// Avalon-MM slave holding NCH independent counters.
// Ports:
//   csi_clk, rsi_reset_n        clock, asynchronous active-low reset
//   avs_s0_*                    MM slave: address {channel, reg[1:0]},
//                               write/read strobes, fixed read latency 1
//   coe_s0_tick                 per-channel count events
//   coe_s0_dout                 counter values, channel c at [c*WIDTH +: WIDTH]
//   coe_s0_ovf                  per-channel sticky overflow flags
module mm_counter_bank
  import mm_counter_bank_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NCH    = 4,
  localparam int ADDR_W = $clog2(NCH) + 2
) (
  input  logic                 csi_clk,
  input  logic                 rsi_reset_n,
  input  logic [ADDR_W-1:0]    avs_s0_address,
  input  logic                 avs_s0_write,
  input  logic [WIDTH-1:0]     avs_s0_writedata,
  input  logic                 avs_s0_read,
  output logic [WIDTH-1:0]     avs_s0_readdata,
  output logic                 avs_s0_readdatavalid,
  output logic                 avs_s0_waitrequest,
  input  logic [NCH-1:0]       coe_s0_tick,
  output logic [NCH*WIDTH-1:0] coe_s0_dout,
  output logic [NCH-1:0]       coe_s0_ovf
);

  logic [ADDR_W-1:0] w_ch;
  logic [1:0]        w_reg;
  logic              w_ch_ok;
  logic [WIDTH-1:0]  w_rd_mux;

  logic [WIDTH-1:0]  w_count [NCH];
  logic [WIDTH-1:0]  w_step  [NCH];
  ctrl_t             w_ctrl  [NCH];

  logic [WIDTH-1:0]  r_rdata;
  logic              r_rvalid;

  // Shift rather than slice so NCH=1 (no channel bits) still elaborates.
  assign w_ch    = avs_s0_address >> 2;
  assign w_reg   = avs_s0_address[1:0];
  assign w_ch_ok = int'(w_ch) < NCH;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      logic w_sel;
      assign w_sel = avs_s0_write && w_ch_ok && (w_ch == ADDR_W'(gi));

      mm_counter_chan #(.WIDTH(WIDTH)) u_chan (
        .clk        (csi_clk),
        .rst_n      (rsi_reset_n),
        .i_wr_count (w_sel && (w_reg == REG_COUNT)),
        .i_wr_step  (w_sel && (w_reg == REG_STEP)),
        .i_wr_ctrl  (w_sel && (w_reg == REG_CTRL)),
        .i_strobe   (w_sel && (w_reg == REG_STROBE)),
        .i_tick     (coe_s0_tick[gi]),
        .i_wdata    (avs_s0_writedata),
        .o_count    (w_count[gi]),
        .o_step     (w_step[gi]),
        .o_ctrl     (w_ctrl[gi])
      );

      assign coe_s0_dout[gi*WIDTH +: WIDTH] = w_count[gi];
      assign coe_s0_ovf[gi]                 = w_ctrl[gi].ovf;
    end
  endgenerate

  // Read mux sees pre-edge register values, so a same-cycle write is not
  // visible in the returned data. Out-of-range channels read as zero.
  always_comb begin
    w_rd_mux = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_ch_ok && (int'(w_ch) == c)) begin
        case (w_reg)
          REG_COUNT: w_rd_mux = w_count[c];
          REG_STEP:  w_rd_mux = w_step[c];
          REG_CTRL:  w_rd_mux = WIDTH'(w_ctrl[c]);
          default:   w_rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= avs_s0_read;
      r_rdata  <= avs_s0_read ? w_rd_mux : '0;
    end
  end

  assign avs_s0_readdata      = r_rdata;
  assign avs_s0_readdatavalid = r_rvalid;
  assign avs_s0_waitrequest   = ~rsi_reset_n;

endmodule

// File: tb/tb_mm_counter_bank.sv
module tb_mm_counter_bank;

  localparam int WIDTH  = 8;
  localparam int NCH    = 4;
  localparam int ADDR_W = $clog2(NCH) + 2;

  logic                 clk;
  logic                 rst_n;
  logic [ADDR_W-1:0]    address;
  logic                 write;
  logic [WIDTH-1:0]     writedata;
  logic                 read;
  logic [WIDTH-1:0]     readdata;
  logic                 readdatavalid;
  logic                 waitrequest;
  logic [NCH-1:0]       tick;
  logic [NCH*WIDTH-1:0] dout;
  logic [NCH-1:0]       ovf;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q [$];
  logic rd_pend;

  mm_counter_bank #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .csi_clk              (clk),
    .rsi_reset_n          (rst_n),
    .avs_s0_address       (address),
    .avs_s0_write         (write),
    .avs_s0_writedata     (writedata),
    .avs_s0_read          (read),
    .avs_s0_readdata      (readdata),
    .avs_s0_readdatavalid (readdatavalid),
    .avs_s0_waitrequest   (waitrequest),
    .coe_s0_tick          (tick),
    .coe_s0_dout          (dout),
    .coe_s0_ovf           (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ch_val(input int c);
    return dout[c*WIDTH +: WIDTH];
  endfunction

  // One clock: capture whether a read is being presented, clock it, then
  // check the response one cycle later against the scoreboard.
  task automatic cyc();
    rd_pend = read;
    @(posedge clk);
    #1;
    chk("rvalid", {31'd0, readdatavalid}, {31'd0, rd_pend});
    if (readdatavalid === 1'b1) begin
      if (exp_q.size() == 0)
        chk("rdata_unexpected", 32'd1, 32'd0);
      else
        chk("rdata", {24'd0, readdata}, {24'd0, exp_q.pop_front()});
    end
    write = 1'b0;
    read  = 1'b0;
    tick  = '0;
  endtask

  task automatic wr(input int c, input int r, input logic [WIDTH-1:0] d);
    address   = ADDR_W'((c << 2) | r);
    writedata = d;
    write     = 1'b1;
    cyc();
  endtask

  task automatic rd(input int c, input int r, input logic [WIDTH-1:0] e);
    address = ADDR_W'((c << 2) | r);
    read    = 1'b1;
    exp_q.push_back(e);
    cyc();
  endtask

  initial begin
    rst_n     = 1'b0;
    address   = '0;
    write     = 1'b0;
    writedata = '0;
    read      = 1'b0;
    tick      = '0;
    #1;
    chk("rst_waitrequest", {31'd0, waitrequest}, 32'd1);
    chk("rst_dout", dout, 32'd0);
    chk("rst_ovf", {28'd0, ovf}, 32'd0);
    chk("rst_rvalid", {31'd0, readdatavalid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("waitrequest_released", {31'd0, waitrequest}, 32'd0);

    // Reset register values, back-to-back reads.
    rd(0, 1, 8'd1);
    rd(0, 2, 8'd0);
    rd(0, 0, 8'd0);

    // Ch1: strobes with STEP=3.
    wr(1, 1, 8'd3);
    wr(1, 3, 8'd0); chk("ch1_s1", ch_val(1), 32'd3);
    wr(1, 3, 8'd0); chk("ch1_s2", ch_val(1), 32'd6);
    wr(1, 3, 8'd0); chk("ch1_s3", ch_val(1), 32'd9);
    chk("ch1_ovf", {31'd0, ovf[1]}, 32'd0);

    // Ch2: wrap with tick, then tick+strobe overflow.
    wr(2, 0, 8'd250);
    wr(2, 1, 8'd4);
    wr(2, 2, 8'h01);
    tick[2] = 1'b1; cyc();
    chk("ch2_t1", ch_val(2), 32'd254);
    tick[2] = 1'b1; wr(2, 3, 8'd0);
    chk("ch2_wrap", ch_val(2), 32'd6);
    chk("ch2_ovf_set", {31'd0, ovf[2]}, 32'd1);
    rd(2, 2, 8'h09);
    wr(2, 2, 8'h08);
    chk("ch2_ovf_clr", {31'd0, ovf[2]}, 32'd0);
    chk("ch1_untouched", ch_val(1), 32'd9);

    // Ch3: saturating down count.
    wr(3, 2, 8'h07);
    wr(3, 0, 8'd5);
    wr(3, 1, 8'd3);
    tick[3] = 1'b1; cyc();
    chk("ch3_t1", ch_val(3), 32'd2);
    chk("ch3_ovf0", {31'd0, ovf[3]}, 32'd0);
    tick[3] = 1'b1; cyc();
    chk("ch3_sat0", ch_val(3), 32'd0);
    chk("ch3_ovf1", {31'd0, ovf[3]}, 32'd1);
    tick[3] = 1'b1; cyc();
    chk("ch3_hold", ch_val(3), 32'd0);
    rd(3, 2, 8'h0F);

    // Ch0: COUNT load beats tick, concurrent read returns old value.
    wr(0, 2, 8'h01);
    wr(0, 3, 8'd0);
    chk("ch0_strobe", ch_val(0), 32'd1);
    tick[0]   = 1'b1;
    address   = ADDR_W'(0);
    writedata = 8'h40;
    write     = 1'b1;
    read      = 1'b1;
    exp_q.push_back(8'd1);
    cyc();
    chk("ch0_load", ch_val(0), 32'h40);
    chk("ch0_ovf", {31'd0, ovf[0]}, 32'd0);

    // Ch0: saturate up, then OVF set beats same-cycle clear.
    wr(0, 2, 8'h05);
    wr(0, 0, 8'hFE);
    wr(0, 1, 8'd2);
    wr(0, 3, 8'd0);
    chk("ch0_satup", ch_val(0), 32'hFF);
    chk("ch0_ovf_set", {31'd0, ovf[0]}, 32'd1);
    tick[0] = 1'b1; wr(0, 2, 8'h0D);
    chk("ch0_set_beats_clr", {31'd0, ovf[0]}, 32'd1);
    chk("ch0_sat_hold", ch_val(0), 32'hFF);
    wr(0, 2, 8'h08);
    chk("ch0_ovf_clr", {31'd0, ovf[0]}, 32'd0);

    // Reset with a read response pending.
    address = ADDR_W'((1 << 2) | 0);
    read    = 1'b1;
    @(posedge clk);
    #1;
    read = 1'b0;
    chk("pre_rst_rvalid", {31'd0, readdatavalid}, 32'd1);
    chk("pre_rst_rdata", {24'd0, readdata}, 32'd9);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", {31'd0, readdatavalid}, 32'd0);
    chk("mid_rst_dout", dout, 32'd0);
    chk("mid_rst_ovf", {28'd0, ovf}, 32'd0);
    chk("mid_rst_waitreq", {31'd0, waitrequest}, 32'd1);
    read = 1'b1;
    @(posedge clk);
    #1;
    read = 1'b0;
    chk("in_rst_rvalid", {31'd0, readdatavalid}, 32'd0);
    chk("in_rst_waitreq", {31'd0, waitrequest}, 32'd1);
    rst_n = 1'b1;
    #1;
    chk("post_rst_waitreq", {31'd0, waitrequest}, 32'd0);
    rd(1, 1, 8'd1);
    rd(2, 2, 8'h00);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
